hpb_wr_bridge: RTL and testbench

- Host-side write bridge directly upstream of the symbol-parameter RAM controller.
- Buffers host configuration writes (address, data, byte enables) in a small FIFO.
- Presents one write at a time on the hpb write-request signals and holds each request stable until the RAM controller returns its write-done pulse.
- Drops the request for one cycle between writes so the controller's sticky ignore flag clears. Also tracks completed writes and flags writes stalled too long by feed traffic.

---
 rtl/hpb_wr_bridge.sv | 197 +++++++++++++++++++
 tb/tb_hpb_wr_bridge.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpb_wr_bridge.sv
// hpb_wr_bridge
// Host-side write bridge in front of the symbol-parameter RAM controller.
// Host writes are buffered in a small FIFO and issued one at a time on the
// hpb write-request interface. Each request is held until rcb_wr_done, then
// dropped for one cycle so the controller's sticky ignore flag can clear.
// Completed writes are counted, and a request stalled for too long raises a
// sticky timeout flag.
module hpb_wr_bridge #(
  parameter int ADDR_W         = 14,
  parameter int DATA_W         = 64,
  parameter int BE_W           = DATA_W / 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        host_wr_valid,
  output logic                        host_wr_ready,
  input  logic [ADDR_W-1:0]           host_wr_addr,
  input  logic [DATA_W-1:0]           host_wr_data,
  input  logic [BE_W-1:0]             host_wr_be,
  output logic                        hpb_wr_req,
  output logic [ADDR_W-1:0]           hpb_wr_addr,
  output logic [DATA_W-1:0]           hpb_wr_data,
  output logic [BE_W-1:0]             hpb_wr_byte_en,
  input  logic                        rcb_wr_done,
  input  logic                        err_clr,
  output logic                        err_timeout,
  output logic [15:0]                 wr_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W + BE_W;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t state, state_nxt;

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              full, empty;
  logic              push, pop;
  logic              done_accept;
  logic              tmo_inc;
  logic              tmo_hit;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [15:0]       done_count;

  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [BE_W-1:0]   head_be;

  assign full          = (level == LVL_W'(FIFO_DEPTH));
  assign empty         = (level == '0);
  // Ready depends only on the current fill, so a full FIFO never accepts a
  // beat even when the FSM pops in the same cycle.
  assign host_wr_ready = !full;
  assign push          = host_wr_valid && !full;
  assign fifo_level    = level;
  assign wr_count      = done_count;
  assign busy          = (state != IDLE) || !empty;

  assign {head_addr, head_data, head_be} = fifo_mem[rd_ptr];

  // The timeout flag fires only on the cycle the stall count reaches the limit.
  assign tmo_hit = tmo_inc && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // FIFO storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {host_wr_addr, host_wr_data, host_wr_be};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (!push && pop) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: pop from IDLE or DROP, wait for done in REQ.
  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    done_accept = 1'b0;
    tmo_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (rcb_wr_done) begin
          done_accept = 1'b1;
          state_nxt   = DROP;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      DROP: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = REQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request outputs: load on pop, drop req on done, otherwise hold last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpb_wr_req     <= 1'b0;
      hpb_wr_addr    <= '0;
      hpb_wr_data    <= '0;
      hpb_wr_byte_en <= '0;
    end else if (pop) begin
      hpb_wr_req     <= 1'b1;
      hpb_wr_addr    <= head_addr;
      hpb_wr_data    <= head_data;
      hpb_wr_byte_en <= head_be;
    end else if (done_accept) begin
      hpb_wr_req     <= 1'b0;
    end
  end

  // Stall counter: restarts on each new request and saturates at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (pop) begin
      tmo_cnt <= '0;
    end else if (tmo_inc && (tmo_cnt != TMO_W'(TIMEOUT_CYCLES))) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Sticky timeout flag; a new timeout wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_timeout <= 1'b0;
    end else if (tmo_hit) begin
      err_timeout <= 1'b1;
    end else if (err_clr) begin
      err_timeout <= 1'b0;
    end
  end

  // Completed-write counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_count <= '0;
    end else if (done_accept) begin
      done_count <= done_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hpb_wr_bridge.sv
// tb_hpb_wr_bridge
// Self-checking bench for hpb_wr_bridge: a directed vector table, directed
// multi-cycle sequences and randomized traffic, all compared against a
// queue-based reference model of the bridge's transaction behaviour.
module tb_hpb_wr_bridge;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 1024;

  logic        clk;
  logic        reset;
  logic        host_wr_valid;
  logic        host_wr_ready;
  logic [13:0] host_wr_addr;
  logic [63:0] host_wr_data;
  logic [7:0]  host_wr_be;
  logic        hpb_wr_req;
  logic [13:0] hpb_wr_addr;
  logic [63:0] hpb_wr_data;
  logic [7:0]  hpb_wr_byte_en;
  logic        rcb_wr_done;
  logic        err_clr;
  logic        err_timeout;
  logic [15:0] wr_count;
  logic [2:0]  fifo_level;
  logic        busy;

  int n_checks;
  int n_fails;

  hpb_wr_bridge dut (
    .clk            (clk),
    .reset          (reset),
    .host_wr_valid  (host_wr_valid),
    .host_wr_ready  (host_wr_ready),
    .host_wr_addr   (host_wr_addr),
    .host_wr_data   (host_wr_data),
    .host_wr_be     (host_wr_be),
    .hpb_wr_req     (hpb_wr_req),
    .hpb_wr_addr    (hpb_wr_addr),
    .hpb_wr_data    (hpb_wr_data),
    .hpb_wr_byte_en (hpb_wr_byte_en),
    .rcb_wr_done    (rcb_wr_done),
    .err_clr        (err_clr),
    .err_timeout    (err_timeout),
    .wr_count       (wr_count),
    .fifo_level     (fifo_level),
    .busy           (busy)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending writes in a queue, plus the write being issued.
  typedef struct packed {
    logic [13:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_t;

  wr_t         m_q[$];
  wr_t         m_cur;
  bit          m_req;
  bit          m_gap;
  int          m_stall;
  bit          m_err;
  logic [15:0] m_count;

  typedef struct {
    logic        valid;
    logic [13:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic        done;
    logic        clr;
    logic        e_req;
    logic [13:0] e_addr;
    logic [63:0] e_data;
    logic [7:0]  e_be;
    logic [15:0] e_count;
    logic [2:0]  e_level;
    logic        e_busy;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cur   = '0;
    m_req   = 1'b0;
    m_gap   = 1'b0;
    m_stall = 0;
    m_err   = 1'b0;
    m_count = 16'd0;
  endtask

  // One clock of transaction-level behaviour, from the inputs about to be sampled.
  task automatic model_step();
    bit set_err;
    int sz;
    set_err = 1'b0;
    sz      = m_q.size();
    if (m_req) begin
      if (rcb_wr_done) begin
        m_req   = 1'b0;
        m_gap   = 1'b1;
        m_count = m_count + 16'd1;
      end else if (m_stall < TIMEOUT) begin
        m_stall++;
        if (m_stall == TIMEOUT) set_err = 1'b1;
      end
    end else begin
      m_gap = 1'b0;
      if (sz > 0) begin
        m_cur   = m_q.pop_front();
        m_req   = 1'b1;
        m_stall = 0;
      end
    end
    if (host_wr_valid && sz < DEPTH) begin
      m_q.push_back({host_wr_addr, host_wr_data, host_wr_be});
    end
    if (set_err) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
  endtask

  task automatic checkOutput();
    check("req",    64'(hpb_wr_req),     64'(m_req));
    check("addr",   64'(hpb_wr_addr),    64'(m_cur.addr));
    check("data",   hpb_wr_data,         m_cur.data);
    check("be",     64'(hpb_wr_byte_en), 64'(m_cur.be));
    check("ready",  64'(host_wr_ready),  64'(m_q.size() < DEPTH));
    check("level",  64'(fifo_level),     64'(m_q.size()));
    check("busy",   64'(busy),           64'(m_req || m_gap || (m_q.size() != 0)));
    check("err",    64'(err_timeout),    64'(m_err));
    check("count",  64'(wr_count),       64'(m_count));
  endtask

  // Advance one clock: update the model, then sample the DUT just after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input vec_t v);
    host_wr_valid = v.valid;
    host_wr_addr  = v.addr;
    host_wr_data  = v.data;
    host_wr_be    = v.be;
    rcb_wr_done   = v.done;
    err_clr       = v.clr;
  endtask

  task automatic push_and_issue(input logic [13:0] a, input logic [63:0] d, input logic [7:0] b);
    host_wr_valid = 1'b1;
    host_wr_addr  = a;
    host_wr_data  = d;
    host_wr_be    = b;
    tick();
    host_wr_valid = 1'b0;
    tick();
    check("issue_req",  64'(hpb_wr_req),  64'd1);
    check("issue_addr", 64'(hpb_wr_addr), 64'(a));
  endtask

  initial begin
    logic [13:0] issued[$];
    bit          prev_req;
    int          gap_len;
    bit          drained;
    int          exp_cnt;

    n_checks = 0;
    n_fails  = 0;

    // Single write followed by a spurious done while idle.
    vecs[0] = '{1'b1, 14'h0123, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b0, 1'b0,
                1'b0, 14'h0000, 64'h0, 8'h00, 16'd0, 3'd1, 1'b1};
    vecs[1] = '{1'b0, 14'h0000, 64'h0, 8'h00, 1'b0, 1'b0,
                1'b1, 14'h0123, 64'hDEADBEEF_CAFEF00D, 8'hFF, 16'd0, 3'd0, 1'b1};
    vecs[2] = '{1'b0, 14'h0000, 64'h0, 8'h00, 1'b0, 1'b0,
                1'b1, 14'h0123, 64'hDEADBEEF_CAFEF00D, 8'hFF, 16'd0, 3'd0, 1'b1};
    vecs[3] = '{1'b0, 14'h0000, 64'h0, 8'h00, 1'b1, 1'b0,
                1'b0, 14'h0123, 64'hDEADBEEF_CAFEF00D, 8'hFF, 16'd1, 3'd0, 1'b1};
    vecs[4] = '{1'b0, 14'h0000, 64'h0, 8'h00, 1'b0, 1'b0,
                1'b0, 14'h0123, 64'hDEADBEEF_CAFEF00D, 8'hFF, 16'd1, 3'd0, 1'b0};
    vecs[5] = '{1'b0, 14'h0000, 64'h0, 8'h00, 1'b1, 1'b0,
                1'b0, 14'h0123, 64'hDEADBEEF_CAFEF00D, 8'hFF, 16'd1, 3'd0, 1'b0};
    vecs[6] = '{1'b0, 14'h0000, 64'h0, 8'h00, 1'b0, 1'b0,
                1'b0, 14'h0123, 64'hDEADBEEF_CAFEF00D, 8'hFF, 16'd1, 3'd0, 1'b0};

    reset         = 1'b1;
    host_wr_valid = 1'b0;
    host_wr_addr  = '0;
    host_wr_data  = '0;
    host_wr_be    = '0;
    rcb_wr_done   = 1'b0;
    err_clr       = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    check("rst_req",   64'(hpb_wr_req),    64'd0);
    check("rst_addr",  64'(hpb_wr_addr),   64'd0);
    check("rst_level", 64'(fifo_level),    64'd0);
    check("rst_ready", 64'(host_wr_ready), 64'd1);
    check("rst_busy",  64'(busy),          64'd0);
    check("rst_err",   64'(err_timeout),   64'd0);
    check("rst_count", 64'(wr_count),      64'd0);
    reset = 1'b0;
    model_reset();

    $display("[TB] vector table");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      tick();
      check($sformatf("vec%0d_req", i),   64'(hpb_wr_req),     64'(vecs[i].e_req));
      check($sformatf("vec%0d_addr", i),  64'(hpb_wr_addr),    64'(vecs[i].e_addr));
      check($sformatf("vec%0d_data", i),  hpb_wr_data,         vecs[i].e_data);
      check($sformatf("vec%0d_be", i),    64'(hpb_wr_byte_en), 64'(vecs[i].e_be));
      check($sformatf("vec%0d_count", i), 64'(wr_count),       64'(vecs[i].e_count));
      check($sformatf("vec%0d_level", i), 64'(fifo_level),     64'(vecs[i].e_level));
      check($sformatf("vec%0d_busy", i),  64'(busy),           64'(vecs[i].e_busy));
    end
    exp_cnt = 1;

    $display("[TB] fill to full, then back-to-back drain");
    rcb_wr_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      host_wr_valid = 1'b1;
      host_wr_addr  = 14'h100 + 14'(i);
      host_wr_data  = {32'h0, $urandom};
      host_wr_be    = 8'(i);
      tick();
    end
    host_wr_addr = 14'h1FF;
    check("full_ready", 64'(host_wr_ready), 64'd0);
    tick();
    check("full_level", 64'(fifo_level), 64'd4);
    host_wr_valid = 1'b0;

    issued.delete();
    issued.push_back(hpb_wr_addr);
    prev_req = hpb_wr_req;
    gap_len  = 0;
    drained  = 1'b0;
    for (int c = 0; c < 40 && !drained; c++) begin
      rcb_wr_done = m_req;
      tick();
      if (hpb_wr_req && !prev_req) begin
        check("b2b_gap", 64'(gap_len), 64'd1);
        issued.push_back(hpb_wr_addr);
        gap_len = 0;
      end else if (!hpb_wr_req) begin
        gap_len++;
      end
      prev_req = hpb_wr_req;
      if (!m_req && !m_gap && m_q.size() == 0) drained = 1'b1;
    end
    rcb_wr_done = 1'b0;
    check("b2b_drained", 64'(drained), 64'd1);
    check("b2b_issued",  64'(issued.size()), 64'd5);
    for (int i = 0; i < issued.size() && i < 5; i++) begin
      check($sformatf("b2b_order%0d", i), 64'(issued[i]), 64'(14'h100 + 14'(i)));
    end
    tick();
    exp_cnt += 5;
    check("b2b_count", 64'(wr_count), 64'(exp_cnt));
    check("b2b_idle",  64'(busy), 64'd0);

    $display("[TB] stalled request");
    push_and_issue(14'h2AA, 64'h1122334455667788, 8'h0F);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("stall_err_early", 64'(err_timeout), 64'd0);
    tick();
    check("stall_err",  64'(err_timeout), 64'd1);
    check("stall_req",  64'(hpb_wr_req),  64'd1);
    check("stall_addr", 64'(hpb_wr_addr), 64'h2AA);
    rcb_wr_done = 1'b1;
    tick();
    rcb_wr_done = 1'b0;
    exp_cnt++;
    repeat (3) tick();
    check("stall_count",    64'(wr_count),    64'(exp_cnt));
    check("stall_err_hold", 64'(err_timeout), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("stall_err_clr", 64'(err_timeout), 64'd0);

    $display("[TB] timeout set beats simultaneous clear");
    push_and_issue(14'h2BB, 64'h0, 8'h00);
    err_clr = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) tick();
    check("prec_set_wins", 64'(err_timeout), 64'd1);
    tick();
    check("prec_clr_after", 64'(err_timeout), 64'd0);
    err_clr     = 1'b0;
    rcb_wr_done = 1'b1;
    tick();
    rcb_wr_done = 1'b0;
    tick();
    exp_cnt++;
    check("prec_count_be0", 64'(wr_count), 64'(exp_cnt));

    $display("[TB] long done pulse");
    push_and_issue(14'h333, 64'hA5A5A5A5A5A5A5A5, 8'hAA);
    rcb_wr_done = 1'b1;
    repeat (3) tick();
    rcb_wr_done = 1'b0;
    tick();
    exp_cnt++;
    check("long_done_count", 64'(wr_count), 64'(exp_cnt));

    $display("[TB] reset during request");
    for (int i = 0; i < 3; i++) begin
      host_wr_valid = 1'b1;
      host_wr_addr  = 14'h401 + 14'(i);
      tick();
    end
    host_wr_valid = 1'b0;
    check("mid_req_active", 64'(hpb_wr_req), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_req",   64'(hpb_wr_req),    64'd0);
    check("mid_rst_level", 64'(fifo_level),    64'd0);
    check("mid_rst_count", 64'(wr_count),      64'd0);
    check("mid_rst_ready", 64'(host_wr_ready), 64'd1);
    check("mid_rst_busy",  64'(busy),          64'd0);
    model_reset();
    @(negedge clk);
    reset       = 1'b0;
    rcb_wr_done = 1'b1;
    tick();
    rcb_wr_done = 1'b0;
    repeat (2) tick();
    check("post_rst_count", 64'(wr_count),   64'd0);
    check("post_rst_req",   64'(hpb_wr_req), 64'd0);

    $display("[TB] counter wrap");
    force dut.done_count = 16'hFFFF;
    #1;
    release dut.done_count;
    m_count = 16'hFFFF;
    check("wrap_preset", 64'(wr_count), 64'hFFFF);
    push_and_issue(14'h555, 64'h5555, 8'h55);
    rcb_wr_done = 1'b1;
    tick();
    rcb_wr_done = 1'b0;
    tick();
    check("wrap_count", 64'(wr_count), 64'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      host_wr_valid = ($urandom_range(0, 1) == 1);
      host_wr_addr  = 14'($urandom);
      host_wr_data  = {$urandom, $urandom};
      host_wr_be    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rcb_wr_done   = ($urandom_range(0, 2) == 0);
      err_clr       = ($urandom_range(0, 49) == 0);
      tick();
    end
    host_wr_valid = 1'b0;
    rcb_wr_done   = 1'b0;
    err_clr       = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
